count_step_monitor: RTL and testbench
=====================================

Name: count_step_monitor

Overview:
- Downstream consumer of the 4-bit synchronous up-counter's count output, sampled every clock edge.
- Checks that the count only holds, increments by one, wraps 15->0, or restarts at 0.
- Flags wraps, counts them, reports programmable-window membership, and latches sticky faults on illegal jumps.
- Used as an on-chip checker and cascade-carry source for the counter stage.

Parameters:
CNT_W, 4, width of monitored count
WRAP_W, 8, width of wrap counter

Ports:
clk  input  1  rising-edge clock, same clock as the up-counter
rst  input  1  asynchronous active-low reset (0 = reset)
count_in  input  CNT_W  count from up-counter
lo  input  CNT_W  window low bound
hi  input  CNT_W  window high bound
clr  input  1  synchronous clear of sticky state and wrap counter
wrap_pulse  output  1  one-cycle pulse on legal max->0 transition
restart_pulse  output  1  one-cycle pulse on non-wrap jump to 0
err_pulse  output  1  one-cycle pulse on illegal transition
err_sticky  output  1  latched fault, held until clr
wrap_count  output  WRAP_W  number of wraps since reset/clr
wrap_ovf  output  1  sticky, set when wrap_count rolls over
in_window  output  1  registered window membership of count_in
state  output  2  FSM state: 0=INIT, 1=TRACK, 2=FAULT

Behaviour:
- Reset (rst=0, async):
  - All outputs 0, state=INIT, prev register 0.
  - Release is sampled on the next rising edge.
- All outputs are registered, so events appear one cycle after the edge that sampled count_in.
- MAX = 2^CNT_W-1. All arithmetic is mod 2^CNT_W.
- INIT:
  - The first edge loads prev<=count_in, goes to TRACK, and generates no event pulses.
  - in_window updates every cycle in every state, including INIT.
- TRACK/FAULT classification each edge, comparing count_in with prev:
  - equal -> hold, no pulse.
  - count_in==prev+1, prev!=MAX -> step, no pulse.
  - prev==MAX and count_in==0 -> wrap_pulse=1. In TRACK only, wrap_count increments.
  - count_in==0 otherwise -> restart_pulse=1, no error.
  - anything else -> err_pulse=1, err_sticky<=1, state<=FAULT.
  - prev<=count_in always.
- Wrap counter:
  - Counts in TRACK only; frozen in FAULT.
  - On increment from 2^WRAP_W-1, it wraps to 0 and wrap_ovf<=1 (sticky).
- FAULT:
  - Classification continues: wrap_pulse, restart_pulse and err_pulse are all still generated.
  - Stays in FAULT until clr.
- clr=1, synchronous, highest priority after reset:
  - err_sticky, wrap_count and wrap_ovf <=0, state<=INIT.
  - No pulses that cycle.
  - prev is reloaded on the following INIT edge.
- Window:
  - If lo<=hi: in_window = lo<=count_in<=hi.
  - If lo>hi (wrapping window): in_window = count_in>=lo or count_in<=hi.
- Pulses are mutually exclusive; at most one is high per cycle.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Test Plan:
- rst=0 for 10 ns, then counter free-runs 0..15..0 with t=1:
  - no pulses on the first sampled edge;
  - wrap_pulse exactly one cycle after count 15->0;
  - wrap_count=1 after the first wrap, 2 after the second;
  - err_sticky stays 0.
- Counter held (t=0) at 7 for 5 cycles -> no pulses, state=TRACK.
- Counter reset to 0 from 9 (mid-count counter reset) -> restart_pulse one cycle later, err_sticky=0, wrap_count unchanged.
- Force count_in 5->8 -> err_pulse one cycle, err_sticky=1, state=FAULT. A subsequent 15->0 gives wrap_pulse but wrap_count unchanged. clr=1 -> err_sticky=0, wrap_count=0, state=INIT.
- Windows:
  - lo=3, hi=6: in_window high for counts 3..6 only.
  - lo=14, hi=1: high for 14, 15, 0, 1 only.
- WRAP_W=2, run 4 full wraps -> wrap_count 1,2,3,0 and wrap_ovf=1 at the 4th. Then rst=0 mid-count -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/count_step_monitor.sv
// Step checker for a free-running up-counter: classifies each sampled count as
// hold/step/wrap/restart/illegal, counts wraps and reports window membership.
module count_step_monitor #(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  count_in,
    input  logic [CNT_W-1:0]  lo,
    input  logic [CNT_W-1:0]  hi,
    input  logic              clr,
    output logic              wrap_pulse,
    output logic              restart_pulse,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              wrap_ovf,
    output logic              in_window,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [WRAP_W-1:0] WRP_ONE = WRAP_W'(1);

    state_t              state_q;
    logic [CNT_W-1:0]    prev_q;
    logic [WRAP_W-1:0]   wrap_count_q;
    logic                wrap_pulse_q, restart_pulse_q, err_pulse_q;
    logic                err_sticky_q, wrap_ovf_q, in_window_q;

    logic is_hold, is_step, is_wrap, is_restart, is_err, win_d;

    // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
    always_comb begin
        is_hold    = (count_in == prev_q);
        is_wrap    = (prev_q == CNT_MAX) && (count_in == '0);
        is_step    = (prev_q != CNT_MAX) && (count_in == prev_q + CNT_ONE);
        is_restart = (count_in == '0) && !is_wrap && !is_hold;
        is_err     = !(is_hold || is_step || is_wrap || is_restart);
        if (lo <= hi) begin
            win_d = (count_in >= lo) && (count_in <= hi);
        end else begin
            win_d = (count_in >= lo) || (count_in <= hi);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_INIT;
            prev_q          <= '0;
            wrap_count_q    <= '0;
            wrap_pulse_q    <= 1'b0;
            restart_pulse_q <= 1'b0;
            err_pulse_q     <= 1'b0;
            err_sticky_q    <= 1'b0;
            wrap_ovf_q      <= 1'b0;
            in_window_q     <= 1'b0;
        end else begin
            in_window_q     <= win_d;
            wrap_pulse_q    <= 1'b0;
            restart_pulse_q <= 1'b0;
            err_pulse_q     <= 1'b0;
            if (clr) begin
                // prev is left alone; the next INIT edge reloads it
                state_q      <= ST_INIT;
                err_sticky_q <= 1'b0;
                wrap_count_q <= '0;
                wrap_ovf_q   <= 1'b0;
            end else if (state_q == ST_INIT) begin
                prev_q  <= count_in;
                state_q <= ST_TRACK;
            end else begin
                prev_q          <= count_in;
                wrap_pulse_q    <= is_wrap;
                restart_pulse_q <= is_restart;
                err_pulse_q     <= is_err;
                if (is_wrap && state_q == ST_TRACK) begin
                    wrap_count_q <= wrap_count_q + WRP_ONE;
                    if (&wrap_count_q) begin
                        wrap_ovf_q <= 1'b1;
                    end
                end
                if (is_err) begin
                    err_sticky_q <= 1'b1;
                    state_q      <= ST_FAULT;
                end
            end
        end
    end

    assign wrap_pulse    = wrap_pulse_q;
    assign restart_pulse = restart_pulse_q;
    assign err_pulse     = err_pulse_q;
    assign err_sticky    = err_sticky_q;
    assign wrap_count    = wrap_count_q;
    assign wrap_ovf      = wrap_ovf_q;
    assign in_window     = in_window_q;
    assign state         = state_q;

endmodule

// File: tb/tb_count_step_monitor.sv
// Drives two monitors (8-bit and 2-bit wrap counters) with directed and random
// count streams and compares every output against a behavioural model.
module tb_count_step_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] count_in, lo, hi;
    logic       clr;

    logic       wp_a, rp_a, ep_a, es_a, ovf_a, win_a;
    logic [7:0] wc_a;
    logic [1:0] st_a;
    logic       wp_b, rp_b, ep_b, es_b, ovf_b, win_b;
    logic [1:0] wc_b;
    logic [1:0] st_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model: wraps counted as an unbounded integer since the last clr/reset.
    int m_state, m_prev, m_wraps;
    bit m_sticky, m_wp, m_rp, m_ep, m_win;

    count_step_monitor #(.CNT_W(4), .WRAP_W(8)) dut_a (
        .clk(clk), .rst(rst), .count_in(count_in), .lo(lo), .hi(hi), .clr(clr),
        .wrap_pulse(wp_a), .restart_pulse(rp_a), .err_pulse(ep_a), .err_sticky(es_a),
        .wrap_count(wc_a), .wrap_ovf(ovf_a), .in_window(win_a), .state(st_a)
    );

    count_step_monitor #(.CNT_W(4), .WRAP_W(2)) dut_b (
        .clk(clk), .rst(rst), .count_in(count_in), .lo(lo), .hi(hi), .clr(clr),
        .wrap_pulse(wp_b), .restart_pulse(rp_b), .err_pulse(ep_b), .err_sticky(es_b),
        .wrap_count(wc_b), .wrap_ovf(ovf_b), .in_window(win_b), .state(st_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_wraps = 0;
        m_sticky = 0; m_wp = 0; m_rp = 0; m_ep = 0; m_win = 0;
    endtask

    task automatic model_edge();
        int c;
        c = int'(count_in);
        m_win = (lo <= hi) ? (count_in >= lo && count_in <= hi)
                           : (count_in >= lo || count_in <= hi);
        m_wp = 0; m_rp = 0; m_ep = 0;
        if (clr) begin
            m_state = 0; m_sticky = 0; m_wraps = 0;
        end else if (m_state == 0) begin
            m_prev = c; m_state = 1;
        end else begin
            if (c == m_prev || (m_prev != 15 && c == m_prev + 1)) begin
                // hold or step: nothing to report
            end else if (m_prev == 15 && c == 0) begin
                m_wp = 1;
                if (m_state == 1) m_wraps++;
            end else if (c == 0) begin
                m_rp = 1;
            end else begin
                m_ep = 1; m_sticky = 1; m_state = 2;
            end
            m_prev = c;
        end
    endtask

    task automatic check_all();
        check("a.wrap_pulse",    int'(wp_a),  int'(m_wp));
        check("a.restart_pulse", int'(rp_a),  int'(m_rp));
        check("a.err_pulse",     int'(ep_a),  int'(m_ep));
        check("a.err_sticky",    int'(es_a),  int'(m_sticky));
        check("a.wrap_count",    int'(wc_a),  m_wraps % 256);
        check("a.wrap_ovf",      int'(ovf_a), int'(m_wraps >= 256));
        check("a.in_window",     int'(win_a), int'(m_win));
        check("a.state",         int'(st_a),  m_state);
        check("b.wrap_pulse",    int'(wp_b),  int'(m_wp));
        check("b.restart_pulse", int'(rp_b),  int'(m_rp));
        check("b.err_pulse",     int'(ep_b),  int'(m_ep));
        check("b.err_sticky",    int'(es_b),  int'(m_sticky));
        check("b.wrap_count",    int'(wc_b),  m_wraps % 4);
        check("b.wrap_ovf",      int'(ovf_b), int'(m_wraps >= 4));
        check("b.in_window",     int'(win_b), int'(m_win));
        check("b.state",         int'(st_b),  m_state);
    endtask

    task automatic cyc(input int c);
        count_in = 4'(c);
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int c;
        int r;
        rst = 1'b0; count_in = 4'd0; lo = 4'd0; hi = 4'd15; clr = 1'b0;
        model_reset();
        #3;
        check_all();
        #7 rst = 1'b1;

        // free run: two wraps, ending at 7
        for (int k = 0; k < 40; k++) cyc(k % 16);
        check("two_wraps", int'(wc_a), 2);
        for (int k = 0; k < 5; k++) cyc(7);
        check("hold_track", int'(st_a), 1);
        cyc(8); cyc(9); cyc(0);
        check("restart_seen", int'(rp_a), 1);
        for (int k = 1; k <= 5; k++) cyc(k);
        cyc(8);
        check("err_seen", int'(ep_a), 1);
        for (int k = 9; k <= 15; k++) cyc(k);
        cyc(0);
        check("fault_wrap_frozen", int'(wc_a), 2);
        clr = 1'b1; cyc(1); clr = 1'b0;
        check("clr_state", int'(st_a), 0);

        lo = 4'd3; hi = 4'd6;
        for (int k = 0; k < 17; k++) cyc(k % 16);
        lo = 4'd14; hi = 4'd1;
        for (int k = 1; k < 17; k++) cyc(k % 16);

        // four more full wraps exercise the 2-bit counter rollover
        clr = 1'b1; cyc(0); clr = 1'b0;
        for (int k = 0; k < 70; k++) cyc(k % 16);
        check("b.ovf_after_4", int'(ovf_b), 1);

        c = 0;
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      c = (c + 1) % 16;
            else if (r < 80) c = c;
            else if (r < 88) c = 0;
            else             c = int'($urandom_range(0, 15));
            if (k % 25 == 0) begin
                lo = 4'($urandom_range(0, 15));
                hi = 4'($urandom_range(0, 15));
            end
            clr = ($urandom_range(0, 99) < 3);
            cyc(c);
        end
        clr = 1'b0;

        // asynchronous reset between clock edges
        for (int k = 0; k < 20; k++) cyc(k % 16);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst = 1'b1;
        for (int k = 3; k < 10; k++) cyc(k);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
